// File: rtl/imm_enc_pkg.sv
// Shared types and rotate helpers for the rotated-immediate encoder and the Val2 decode side.
// Both directions use these helpers so encode and decode agree bit for bit.
package imm_enc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } enc_state_e;

  localparam int ROT_STEPS   = 16;
  localparam int IMM_FIELD_W = 8;
  localparam int ROT_FIELD_W = 4;

  function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] dbl;
    dbl = {value, value} << amount;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] dbl;
    dbl = {value, value} >> amount;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/rot_candidate_check.sv
// Tests one candidate rotation: value is encodable at rotate_imm r when
// rotating it left by 2r leaves nothing above the 8-bit immediate field.
module rot_candidate_check
  import imm_enc_pkg::*;
(
  input  logic [31:0]            value,
  input  logic [ROT_FIELD_W-1:0] r,
  output logic                   match,
  output logic [IMM_FIELD_W-1:0] imm8
);

  logic [31:0] rotated;

  assign rotated = rol32(value, {r, 1'b0});
  assign match   = (rotated[31:IMM_FIELD_W] == '0);
  assign imm8    = rotated[IMM_FIELD_W-1:0];

endmodule

// File: rtl/imm_rotate_encoder.sv
// Iterative search for the ARM rotated-immediate encoding {rotate_imm, imm8} of a 32-bit constant.
// Optional macro ENC_INVERT_EN adds a second search on ~value (MVN form) when the first one fails.
module imm_rotate_encoder
  import imm_enc_pkg::*;
#(
  parameter int ROT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        encodable,
  output logic [11:0] shifter_operand,
  output logic        inverted
);

  if (!(ROT_PER_CYCLE == 1 || ROT_PER_CYCLE == 2 || ROT_PER_CYCLE == 4 ||
        ROT_PER_CYCLE == 8 || ROT_PER_CYCLE == 16)) begin : g_bad_param
    $error("imm_rotate_encoder: ROT_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

`ifdef ENC_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [ROT_FIELD_W-1:0] RC_STEP = ROT_FIELD_W'(ROT_PER_CYCLE);
  localparam logic [ROT_FIELD_W-1:0] RC_LAST = ROT_FIELD_W'(ROT_STEPS - ROT_PER_CYCLE);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and a presented result holds until it is taken.
  enc_state_e             state_q, state_d;
  logic [ROT_FIELD_W-1:0] rc_q, rc_d;
  logic                   phase_q, phase_d;
  logic [31:0]            value_q, value_d;
  logic                   enc_q, enc_d;
  logic [11:0]            op_q, op_d;
  logic                   inv_q, inv_d;

  logic [31:0]            search_val;
  logic [ROT_PER_CYCLE-1:0] cand_match;
  logic [IMM_FIELD_W-1:0] cand_imm [ROT_PER_CYCLE];
  logic [ROT_FIELD_W-1:0] cand_r   [ROT_PER_CYCLE];
  logic                   found;
  logic [ROT_FIELD_W-1:0] sel_r;
  logic [IMM_FIELD_W-1:0] sel_imm;

  assign search_val = phase_q ? ~value_q : value_q;

  for (genvar g = 0; g < ROT_PER_CYCLE; g++) begin : g_cand
    assign cand_r[g] = rc_q + ROT_FIELD_W'(g);
    rot_candidate_check u_check (
      .value (search_val),
      .r     (cand_r[g]),
      .match (cand_match[g]),
      .imm8  (cand_imm[g])
    );
  end

  // Lowest-index match wins, which gives the smallest rotate_imm.
  always_comb begin
    found   = 1'b0;
    sel_r   = '0;
    sel_imm = '0;
    for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
      if (cand_match[i]) begin
        found   = 1'b1;
        sel_r   = cand_r[i];
        sel_imm = cand_imm[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    phase_d = phase_q;
    value_d = value_q;
    enc_d   = enc_q;
    op_d    = op_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d = value;
          rc_d    = '0;
          phase_d = 1'b0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (found) begin
          enc_d   = 1'b1;
          op_d    = {sel_r, sel_imm};
          inv_d   = phase_q;
          state_d = DONE;
        end else if (rc_q == RC_LAST) begin
          if (INV_EN && !phase_q) begin
            phase_d = 1'b1;
            rc_d    = '0;
          end else begin
            enc_d   = 1'b0;
            op_d    = '0;
            inv_d   = 1'b0;
            state_d = DONE;
          end
        end else begin
          rc_d = rc_q + RC_STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          enc_d   = 1'b0;
          op_d    = '0;
          inv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      phase_q <= 1'b0;
      value_q <= '0;
      enc_q   <= 1'b0;
      op_q    <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      phase_q <= phase_d;
      value_q <= value_d;
      enc_q   <= enc_d;
      op_q    <= op_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign encodable       = enc_q;
  assign shifter_operand = op_q;
  assign inverted        = inv_q;

endmodule

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
- Inverse of the Val2 immediate path: takes a 32-bit constant and searches for the ARM data-processing rotated-immediate encoding {rotate_imm[3:0], imm8[7:0]}.
- The encoding is defined by value == ROR(imm8, 2*rotate_imm).
- Iterative search, one or more candidate rotations per cycle, with valid/ready handshakes on both sides.
- Used by the assembler/test-vector front end, and by constant-materialisation logic, ahead of the decode stage.

Parameters:
ROT_PER_CYCLE, 1, candidate rotations evaluated per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  value is offered.
in_ready  out  1  block can accept a value.
value  in  32  constant to encode.
out_valid  out  1  result is presented.
out_ready  in  1  consumer takes the result.
encodable  out  1  1 = encoding found.
shifter_operand  out  12  {rotate_imm, imm8}; 12'h000 when encodable = 0.
inverted  out  1  1 = encoding is of ~value (MVN form); constant 0 unless ENC_INVERT_EN.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state goes to IDLE.
  - in_ready = 1; out_valid = 0, encodable = 0, shifter_operand = 0, inverted = 0.
  - Reset mid-search or in DONE discards the transaction; no partial result is ever shown.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready = 1.
  - An accept (in_valid & in_ready at edge E0) registers value, clears the rotation counter rc to 0, and moves to SEARCH.
- SEARCH:
  - in_ready = 0.
  - Each cycle, evaluate candidates r = rc .. rc+ROT_PER_CYCLE-1.
  - Candidate r matches when ROL(value_q, 2r)[31:8] == 0.
  - The smallest matching r wins.
  - On a match, at the next edge: go to DONE; encodable = 1; shifter_operand = {r[3:0], ROL(value_q, 2r)[7:0]}.
  - No match: rc += ROT_PER_CYCLE.
  - If the group containing r = 15 fails: DONE with encodable = 0 and shifter_operand = 0.
- Latency:
  - Match at rotation k: out_valid rises at edge E(floor(k/ROT_PER_CYCLE) + 1).
  - No match: out_valid rises at edge E(16/ROT_PER_CYCLE).
- DONE:
  - out_valid = 1; outputs are held stable while out_ready = 0, for an unlimited number of cycles.
  - out_valid & out_ready at an edge: return to IDLE, out_valid = 0.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept; the next accept happens at the earliest one cycle later.
- Canonical choice: the smallest rotate_imm is always reported.
  - value = 0 gives rot 0, imm8 0, at E1.
  - Values with multiple encodings (e.g. 0x0000003F) report rot 0.
- Arithmetic: rotations are modulo 32; 2r is in 0..30, so only even rotations are searched.
- in_valid while in_ready = 0 is ignored; value may change freely then.

Optional Feature:
- Macro: ENC_INVERT_EN.
- Defined:
  - If the normal search fails, a second search runs on ~value_q, with identical rules and with rc reset to 0.
  - A match in the second search gives encodable = 1 and inverted = 1.
  - Worst-case latency doubles: no-match out_valid at E(32/ROT_PER_CYCLE).
  - A first-search match always takes priority, with inverted = 0.
- Undefined: inverted is tied to 0 and there is no second search.

Decomposition:
- Shared package imm_enc_pkg:
  - state enum (IDLE, SEARCH, DONE);
  - ROT_STEPS = 16;
  - function rol32(value, amount);
  - constant IMM_FIELD_W = 8.
  - Rotate helpers are shared with the Val2 decode side for bit-exact agreement.
- One sub-module, rot_candidate_check (combinational):
  - inputs value, r; outputs match and imm8;
  - instantiated ROT_PER_CYCLE times;
  - priority pick in the parent.

Test Plan:
- value 0x000000FF, P = 1 -> out_valid at E1, encodable 1, shifter_operand 0x0FF.
- value 0xFF000000, P = 1 -> E5, shifter_operand 0x4FF; with P = 4 -> E2, same operand.
- value 0x000003FC, P = 1 -> E16, shifter_operand 0xFFF (rot 15); cross-check through Val2 decode gives 0x000003FC.
- value 0x00000101 -> E16, encodable 0, operand 0x000.
  - With ENC_INVERT_EN, value 0xFFFFFF00 -> encodable 1, inverted 1, operand 0x0FF.
- Hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0; release -> IDLE next edge.
  - Then rst_n = 0 during SEARCH for 0x3FC -> next edge in IDLE with out_valid 0; a subsequent 0xFF encodes normally.
- Random sweep: 10k values, both P extremes, macro on and off.
  - Pass criterion: ROR(imm8, 2*rot) == value (or ~value when inverted = 1).
  - Encodability matches a reference model, and the minimal rot is reported.
